pc_ctrl_unit: RTL
=================

PC_CTRL_UNIT -- requirements
Module: pc_ctrl_unit

Interface
REQ-001 SHALL have parameter XLEN, default 16, giving the PC and register-value width.
REQ-002 SHALL have parameter IMM_W, default 9, giving the branch-immediate width, with IMM_W < XLEN.
REQ-003 SHALL have parameter INST_BYTES, default 2, giving the sequential PC increment.
REQ-004 SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-005 SHALL have port clk  in  1  system clock; the block is clocked on the rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port inst_valid  in  1  opcode/cond/imm/rs_val/flags are valid this cycle.
REQ-008 SHALL have port stall  in  1  hold all state this cycle.
REQ-009 SHALL have port opcode  in  4  instruction opcode: B=1100, BR=1101, PCS=1110, HLT=1111, anything else=sequential.
REQ-010 SHALL have port cond  in  3  branch condition code ccc.
REQ-011 SHALL have port imm  in  IMM_W  signed word offset for B.
REQ-012 SHALL have port flags  in  3  {N,V,Z}.
REQ-013 SHALL have port rs_val  in  XLEN  target for BR.
REQ-014 SHALL have port pc  out  XLEN  registered current PC.
REQ-015 SHALL have port branch_taken  out  1  registered; the last retired branch was taken.
REQ-016 SHALL have port flush  out  1  registered one-cycle pulse after a taken branch.
REQ-017 SHALL have port wr_en  out  1  registered PCS register-write strobe.
REQ-018 SHALL have port wr_val  out  XLEN  registered PCS write data; 0 when wr_en=0.
REQ-019 SHALL have port halted  out  1  the FSM is in HALT.

Function
REQ-020 SHALL use a two-state FSM, RUN->HALT, entered when an HLT retires; HALT is left only by reset.
REQ-021 SHALL retire an instruction when inst_valid=1, stall=0 and state=RUN; all updates SHALL occur at that clock edge (latency 1).
REQ-022 SHALL compute seq = pc+INST_BYTES and tgt_b = seq + (sign_ext(imm)<<1), both modulo 2^XLEN (wrap-around, no overflow flag).
REQ-023 SHALL evaluate the conditions as: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 N|Z; 110 V; 111 always.
REQ-024 SHALL set next pc to tgt_b (B) or rs_val (BR) when the condition is true, and to seq otherwise.
REQ-025 SHALL, when a PCS retires, set wr_en=1 and wr_val=seq for exactly one cycle, and advance pc to seq.
REQ-026 SHALL, when an HLT retires, hold pc unchanged and set halted=1 from the next cycle onward.
REQ-027 SHALL set pc=seq for any other opcode.
REQ-028 SHALL set branch_taken equal to the condition result of each retired B/BR, and 0 for any other retired opcode; it holds its value when no instruction retires.
REQ-029 SHALL pulse flush for exactly one cycle after each retired taken B/BR.
REQ-030 SHALL deassert wr_en and flush on any cycle in which no instruction retires.
REQ-031 SHALL give stall priority over inst_valid: a stalled HLT or branch has no effect.
REQ-032 SHALL ignore inst_valid in HALT; pc, wr_en=0, flush=0 and branch_taken SHALL all hold.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force pc=RESET_PC, state=RUN, halted=0, branch_taken=0, flush=0, wr_en=0, wr_val=0, and the statistics counters to 0.
REQ-034 SHALL abandon any in-flight or halted state when reset is asserted mid-operation; the first retirement after release SHALL use pc=RESET_PC.

Configuration
REQ-035 SHALL, when macro PC_CTRL_BRANCH_STATS_EN is defined, add outputs br_count[15:0] and br_taken_count[15:0].
REQ-036 SHALL increment br_count on each retired B/BR and br_taken_count on each retired taken B/BR, saturating at 16'hFFFF.
REQ-037 SHALL, without PC_CTRL_BRANCH_STATS_EN, have neither the ports nor the counter logic.

Structure
REQ-038 SHALL take the opcode constants, cond encodings and FSM state enum from shared package pc_ctrl_pkg.
REQ-039 SHALL place the condition evaluation in combinational sub-module pc_cond_eval (inputs cond and flags; output taken).

Verification
REQ-040 SHALL verify: reset, then 3 sequential retirements -> pc = 0, 2, 4, 6; flush = 0 throughout.
REQ-041 SHALL verify: pc=0x0010, B cond=001, Z=1, imm=9'h1FE -> pc=0x000E; branch_taken=1; flush pulses for 1 cycle. The same with Z=0 -> pc=0x0012; flush=0.
REQ-042 SHALL verify: pc=0xFFFE, sequential -> pc=0x0000 (wrap); BR cond=111, rs_val=0x1234 -> pc=0x1234.
REQ-043 SHALL verify: PCS at pc=0x0020 -> wr_en=1 and wr_val=0x0022 for one cycle; HLT with stall=1 -> no effect; HLT with stall=0 -> halted=1, pc frozen under further valid instructions.
REQ-044 SHALL verify: rst_n asserted mid-branch and while halted -> all outputs reach reset values immediately, without waiting for a clock edge.
REQ-045 SHALL verify, with PC_CTRL_BRANCH_STATS_EN defined: 4 branches, 3 taken -> br_count=4, br_taken_count=3; a counter preloaded near saturation stays at 0xFFFF.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared constants for the program-counter control unit:
//   - opcode values recognised by the PC unit (B, BR, PCS, HLT)
//   - branch condition codes (ccc field)
//   - run/halt FSM state enum
// No ports; imported by pc_cond_eval and pc_ctrl_unit.
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

  // Opcodes that change PC behaviour; every other value is a plain sequential op.
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Condition codes, flags are {N,V,Z}.
  localparam logic [2:0] CC_NE = 3'b000;  // ~Z
  localparam logic [2:0] CC_EQ = 3'b001;  // Z
  localparam logic [2:0] CC_GT = 3'b010;  // ~Z & ~N
  localparam logic [2:0] CC_LT = 3'b011;  // N
  localparam logic [2:0] CC_GE = 3'b100;  // Z | ~N
  localparam logic [2:0] CC_LE = 3'b101;  // N | Z
  localparam logic [2:0] CC_OV = 3'b110;  // V
  localparam logic [2:0] CC_UN = 3'b111;  // always

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

endpackage : pc_ctrl_pkg

// File: rtl/pc_cond_eval.sv
// -----------------------------------------------------------------------------
// pc_cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   cond  [2:0] in   condition code ccc
//   flags [2:0] in   {N,V,Z}
//   taken       out  1 when the condition holds
// -----------------------------------------------------------------------------
module pc_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic flag_n;
  logic flag_v;
  logic flag_z;

  assign flag_n = flags[2];
  assign flag_v = flags[1];
  assign flag_z = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~flag_z;
      CC_EQ:   taken = flag_z;
      CC_GT:   taken = ~flag_z & ~flag_n;
      CC_LT:   taken = flag_n;
      CC_GE:   taken = flag_z | ~flag_n;
      CC_LE:   taken = flag_n | flag_z;
      CC_OV:   taken = flag_v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule : pc_cond_eval

// File: rtl/pc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pc_ctrl_unit
// Program-counter control: sequential advance, conditional PC-relative (B) and
// register (BR) branches, PC-save (PCS) register write, and halt (HLT).
// An instruction retires when inst_valid=1, stall=0 and the FSM is in RUN;
// all outputs are registered and update on the retiring clock edge.
//
// Parameters: XLEN, IMM_W (< XLEN), INST_BYTES, RESET_PC.
// Ports:
//   clk, rst_n (async active-low)
//   inst_valid, stall, opcode[3:0], cond[2:0], imm[IMM_W-1:0], flags[2:0]={N,V,Z},
//   rs_val[XLEN-1:0]                                   -- inputs
//   pc, branch_taken, flush, wr_en, wr_val, halted     -- outputs
// Optional feature (macro PC_CTRL_BRANCH_STATS_EN):
//   br_count[15:0], br_taken_count[15:0] -- saturating retired / taken branch counts
// -----------------------------------------------------------------------------
module pc_ctrl_unit
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN       = 16,
  parameter int IMM_W      = 9,
  parameter int INST_BYTES = 2,
  parameter int RESET_PC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic [3:0]       opcode,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [2:0]       flags,
  input  logic [XLEN-1:0]  rs_val,
  output logic [XLEN-1:0]  pc,
  output logic             branch_taken,
  output logic             flush,
  output logic             wr_en,
  output logic [XLEN-1:0]  wr_val,
  output logic             halted
`ifdef PC_CTRL_BRANCH_STATS_EN
  ,
  output logic [15:0]      br_count,
  output logic [15:0]      br_taken_count
`endif
);

  localparam logic [XLEN-1:0] RESET_PC_V = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INST_BYTES);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            br_taken_q, br_taken_d;
  logic            flush_q, flush_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] wr_val_q, wr_val_d;

  logic            retire;
  logic            cond_true;
  logic            is_branch;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] tgt_b;

  pc_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (cond_true)
  );

  assign retire    = inst_valid & ~stall & (state_q == ST_RUN);
  assign is_branch = (opcode == OP_B) | (opcode == OP_BR);

  // Immediate is a signed word offset: sign-extend, then scale to bytes.
  // All additions wrap modulo 2^XLEN by width truncation.
  assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign seq_pc  = pc_q + INC_V;
  assign tgt_b   = seq_pc + (imm_ext << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC_V;
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_taken_q <= br_taken_d;
      flush_q    <= flush_d;
      wr_en_q    <= wr_en_d;
      wr_val_q   <= wr_val_d;
    end
  end

  // Next-state and registered-output logic. flush/wr_en/wr_val fall back to 0
  // whenever nothing retires; pc, branch_taken and the FSM hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_taken_d = br_taken_q;
    flush_d    = 1'b0;
    wr_en_d    = 1'b0;
    wr_val_d   = '0;

    if (retire) begin
      br_taken_d = 1'b0;
      case (opcode)
        OP_B: begin
          br_taken_d = cond_true;
          flush_d    = cond_true;
          pc_d       = cond_true ? tgt_b : seq_pc;
        end
        OP_BR: begin
          br_taken_d = cond_true;
          flush_d    = cond_true;
          pc_d       = cond_true ? rs_val : seq_pc;
        end
        OP_PCS: begin
          wr_en_d  = 1'b1;
          wr_val_d = seq_pc;
          pc_d     = seq_pc;
        end
        OP_HLT: begin
          state_d = ST_HALT;
        end
        default: begin
          pc_d = seq_pc;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign branch_taken = br_taken_q;
  assign flush        = flush_q;
  assign wr_en        = wr_en_q;
  assign wr_val       = wr_val_q;
  assign halted       = (state_q == ST_HALT);

`ifdef PC_CTRL_BRANCH_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] br_tkn_cnt_q, br_tkn_cnt_d;

  always_comb begin
    br_cnt_d     = br_cnt_q;
    br_tkn_cnt_d = br_tkn_cnt_q;
    if (retire && is_branch) begin
      if (br_cnt_q != 16'hFFFF) begin
        br_cnt_d = br_cnt_q + 16'd1;
      end
      if (cond_true && (br_tkn_cnt_q != 16'hFFFF)) begin
        br_tkn_cnt_d = br_tkn_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q     <= '0;
      br_tkn_cnt_q <= '0;
    end else begin
      br_cnt_q     <= br_cnt_d;
      br_tkn_cnt_q <= br_tkn_cnt_d;
    end
  end

  assign br_count       = br_cnt_q;
  assign br_taken_count = br_tkn_cnt_q;
`else
  logic unused_is_branch;
  assign unused_is_branch = is_branch;
`endif

endmodule : pc_ctrl_unit
